apb_rr_master_ctrl: RTL and testbench

- Shares the single APB master port between NREQ on-chip requesters, such as a CPU-side port and a DMA port.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases itself.
- Routes the transfer to slave 1 or slave 2 by the top address bit.
- Returns read data and error to the granted requester.
- Sits between requesters and the existing APB slaves, replacing the ad-hoc transfer/READ_WRITE strobes.

---
 rtl/apb_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/apb_rr_master_ctrl.sv | 159 +++++++++++++++
 tb/tb_apb_rr_master_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared types and defaults for the round-robin APB master controller.
package apb_ctrl_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int DEF_ADDR_W  = 33;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // The top address bit routes the transfer: 0 = slave 1, 1 = slave 2
  function automatic int sel_bit(input int addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);

  logic found;
  int   pos;

  // Scan from the pointer and take the first active request
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos = (int'(ptr_i) + i) % NREQ;
      if (en_i && !found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master_ctrl.sv
// Shares one APB master port between NREQ requesters. Round-robin grant in
// IDLE, then SETUP/ACCESS phases, then a one-cycle response pulse back to the
// granted requester. The slave is chosen by the top address bit.
// Handshake: request i is consumed in a cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is only ever high in IDLE and only for
// the single granted requester; rsp_valid is a one-cycle one-hot pulse.
module apb_rr_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   PSEL1,
  output logic                   PSEL2,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic                   PREADY,
  input  logic [DATA_W-1:0]      PRDATA,
  input  logic                   PSLVERR
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SB    = sel_bit(ADDR_W);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  apb_state_e         state_q, state_d;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      gidx_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               write_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NREQ-1:0]    arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_en;
  logic               grant_any;
  logic               timeout_hit;
  logic [PW-1:0]      ptr_nxt;

  // No grant is offered while reset is asserted, so nothing is consumed then
  assign arb_en    = (state_q == ST_IDLE) && !PRESET;
  assign grant_any = |arb_gnt;
  assign ptr_nxt   = PW'((int'(arb_idx) + 1) % NREQ);

  // Last waiting ACCESS cycle: counter is about to reach TIMEOUT
  assign timeout_hit = (TIMEOUT != 0) && !PREADY && (cnt_q == CNT_W'(TIMEOUT - 1));

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_any) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || timeout_hit) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Transfer latch, round-robin pointer, wait counter and response capture
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ptr_q   <= '0;
      gidx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && grant_any) begin
        addr_q  <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
        write_q <= req_write[arb_idx];
        gidx_q  <= arb_idx;
        ptr_q   <= ptr_nxt;
      end
      if (state_q == ST_SETUP) cnt_q <= '0;
      if (state_q == ST_ACCESS) begin
        if (PREADY) begin
          rdata_q <= write_q ? '0 : PRDATA;
          err_q   <= PSLVERR;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Outputs decoded from state and the transfer latch
  always_comb begin
    req_ready = arb_gnt;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    busy      = 1'b0;
    PSEL1     = 1'b0;
    PSEL2     = 1'b0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    PADDR     = addr_q;
    PWDATA    = wdata_q;
    case (state_q)
      ST_SETUP, ST_ACCESS: begin
        busy    = 1'b1;
        PSEL1   = ~addr_q[SB];
        PSEL2   = addr_q[SB];
        PWRITE  = write_q;
        PENABLE = (state_q == ST_ACCESS);
      end
      ST_RESP: begin
        rsp_valid[gidx_q] = 1'b1;
        rsp_rdata         = rdata_q;
        rsp_err           = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_rr_master_ctrl.sv
// Directed bench for apb_rr_master_ctrl with NREQ = 2, TIMEOUT = 16.
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
module tb_apb_rr_master_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid, req_write;
  logic [65:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err, busy, PSEL1, PSEL2, PENABLE, PWRITE;
  logic [32:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  logic [4:0]  vec;
  int          checks = 0;
  int          errors = 0;

  // {PSEL1, PSEL2, PENABLE, PWRITE, busy}
  assign vec = {PSEL1, PSEL2, PENABLE, PWRITE, busy};

  apb_rr_master_ctrl #(
    .NREQ(2), .ADDR_W(33), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // Clock
  always #5 PCLK = ~PCLK;

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    cyc(); cyc(); #1;
    checks++; if (vec !== 5'b00000) begin errors++; $display("FAIL reset_apb got %b exp %b", vec, 5'b00000); end
    checks++; if (PADDR !== 33'h0) begin errors++; $display("FAIL reset_paddr got %h exp 0", PADDR); end
    checks++; if (PWDATA !== 32'h0) begin errors++; $display("FAIL reset_pwdata got %h exp 0", PWDATA); end
    checks++; if ({rsp_valid, rsp_err, req_ready} !== 5'b0) begin errors++; $display("FAIL reset_rsp got %b exp 0", {rsp_valid, rsp_err, req_ready}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    PRESET = 1'b0;
    cyc();
  endtask

  task automatic test_write();
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[32:0] = 33'h0_0000_000C; req_wdata[31:0] = 32'h0000_0009;
    PREADY = 1'b1; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL write_accept got %b exp 01", req_ready); end
    cyc(); req_valid = 2'b00; #1;
    checks++; if (vec !== 5'b10011) begin errors++; $display("FAIL write_setup got %b exp 10011", vec); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL write_ready_busy got %b exp 00", req_ready); end
    cyc(); #1;
    checks++; if (vec !== 5'b10111) begin errors++; $display("FAIL write_access got %b exp 10111", vec); end
    checks++; if (PADDR !== 33'd12 || PWDATA !== 32'd9) begin errors++; $display("FAIL write_addr_data got %h/%h exp c/9", PADDR, PWDATA); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL write_early_rsp got %b exp 00", rsp_valid); end
    cyc(); #1;
    checks++; if ({rsp_valid, rsp_err, vec} !== {2'b01, 1'b0, 5'b00000}) begin errors++; $display("FAIL write_resp got %b exp 010_00000", {rsp_valid, rsp_err, vec}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata got %h exp 0", rsp_rdata); end
    cyc(); #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL write_pulse got %b exp 00", rsp_valid); end
  endtask

  task automatic test_read_slave2();
    req_valid = 2'b10; req_write = 2'b00;
    req_addr[65:33] = {1'b1, 32'd5}; PREADY = 1'b0; PRDATA = '0; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL read_accept got %b exp 10", req_ready); end
    cyc(); req_valid = 2'b00; #1;
    checks++; if (vec !== 5'b01001) begin errors++; $display("FAIL read_setup got %b exp 01001", vec); end
    checks++; if (PADDR !== 33'h1_0000_0005) begin errors++; $display("FAIL read_paddr got %h exp 100000005", PADDR); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) begin PREADY = 1'b1; PRDATA = 32'h0000_0023; end
      #1;
      checks++; if ({vec, rsp_valid} !== {5'b01101, 2'b00}) begin errors++; $display("FAIL read_access%0d got %b exp 0110100", i, {vec, rsp_valid}); end
    end
    cyc(); PREADY = 1'b0; #1;
    checks++; if ({rsp_valid, rsp_err} !== 3'b100) begin errors++; $display("FAIL read_resp got %b exp 100", {rsp_valid, rsp_err}); end
    checks++; if (rsp_rdata !== 32'd35) begin errors++; $display("FAIL read_rdata got %h exp 23", rsp_rdata); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_g;
    logic [32:0] exp_a;
    req_valid = 2'b11; req_write = 2'b00;
    req_addr[32:0] = 33'h0_0000_0010; req_addr[65:33] = 33'h1_0000_0020;
    PREADY = 1'b1; PRDATA = 32'h0000_005A;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 33'h0_0000_0010 : 33'h1_0000_0020;
      #1;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL b2b_grant%0d got %b exp %b", k, req_ready, exp_g); end
      cyc(); #1;
      checks++; if (PADDR !== exp_a) begin errors++; $display("FAIL b2b_paddr%0d got %h exp %h", k, PADDR, exp_a); end
      cyc(); cyc(); #1;
      checks++; if (rsp_valid !== exp_g || rsp_rdata !== 32'h5A) begin errors++; $display("FAIL b2b_resp%0d got %b/%h exp %b/5a", k, rsp_valid, rsp_rdata, exp_g); end
      cyc();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    req_valid = 2'b01; req_write = 2'b00; req_addr[32:0] = 33'h0_0000_0007;
    PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL tmo_accept got %b exp 01", req_ready); end
    cyc(); req_valid = 2'b00;
    cyc();
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (vec !== 5'b10101) begin errors++; $display("FAIL tmo_access%0d got %b exp 10101", i, vec); end
      cyc();
    end
    #1;
    checks++; if ({vec, rsp_valid, rsp_err} !== {5'b00000, 2'b01, 1'b1}) begin errors++; $display("FAIL tmo_resp got %b exp 00000011", {vec, rsp_valid, rsp_err}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h exp 0", rsp_rdata); end
    cyc();
    req_valid = 2'b10; req_addr[65:33] = {1'b1, 32'h8}; PREADY = 1'b1; PRDATA = 32'h0000_0077; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL tmo_next_accept got %b exp 10", req_ready); end
    cyc(); req_valid = 2'b00; cyc(); cyc(); #1;
    checks++; if ({rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'h77) begin errors++; $display("FAIL tmo_next_resp got %b/%h exp 100/77", {rsp_valid, rsp_err}, rsp_rdata); end
    cyc();
  endtask

  task automatic test_slverr();
    req_valid = 2'b01; req_write = 2'b00; req_addr[32:0] = 33'd45;
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'h0000_ABCD; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL err_accept got %b exp 01", req_ready); end
    cyc(); req_valid = 2'b00; cyc(); cyc(); PREADY = 1'b1; #1;
    checks++; if (vec !== 5'b10101) begin errors++; $display("FAIL err_wait_ignored got %b exp 10101", vec); end
    cyc(); PREADY = 1'b0; PSLVERR = 1'b0; #1;
    checks++; if ({rsp_valid, rsp_err} !== 3'b011 || rsp_rdata !== 32'hABCD) begin errors++; $display("FAIL err_resp got %b/%h exp 011/abcd", {rsp_valid, rsp_err}, rsp_rdata); end
    cyc();
    req_valid = 2'b10; req_addr[65:33] = 33'd45; PSLVERR = 1'b1; PRDATA = 32'h0000_1234;
    cyc(); req_valid = 2'b00; cyc(); cyc(); PREADY = 1'b1; PSLVERR = 1'b0; cyc(); PREADY = 1'b0; #1;
    checks++; if ({rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'h1234) begin errors++; $display("FAIL err_noready_resp got %b/%h exp 100/1234", {rsp_valid, rsp_err}, rsp_rdata); end
    cyc();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_write = 2'b01; req_addr[32:0] = 33'h1_0000_0030; req_wdata[31:0] = 32'h55;
    PREADY = 1'b0; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_accept got %b exp 01", req_ready); end
    cyc(); req_valid = 2'b00; cyc(); #1;
    checks++; if (vec !== 5'b01111) begin errors++; $display("FAIL rst_access got %b exp 01111", vec); end
    PRESET = 1'b1;
    cyc(); #1;
    checks++; if ({vec, rsp_valid, rsp_err, req_ready} !== 10'b0) begin errors++; $display("FAIL rst_mid_ctrl got %b exp 0", {vec, rsp_valid, rsp_err, req_ready}); end
    checks++; if (PADDR !== 33'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_data got %h/%h/%h exp 0/0/0", PADDR, PWDATA, rsp_rdata); end
    PRESET = 1'b0;
    cyc(); #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_no_rsp got %b exp 00", rsp_valid); end
    req_valid = 2'b11; req_write = 2'b00; req_addr[32:0] = 33'h4; req_addr[65:33] = 33'h1_0000_0008;
    PREADY = 1'b1; PRDATA = 32'h99; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_ptr_grant got %b exp 01", req_ready); end
    cyc(); req_valid = 2'b10; cyc(); cyc(); #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h99) begin errors++; $display("FAIL rst_resp0 got %b/%h exp 01/99", rsp_valid, rsp_rdata); end
    cyc(); #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rst_waiting_grant got %b exp 10", req_ready); end
    cyc(); req_valid = 2'b00; cyc(); cyc(); #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rst_resp1 got %b exp 10", rsp_valid); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_slave2();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
